// File: rtl/cell_stream_sequencer.sv
// Streams 3x3 cell pairs into CellProcessor under valid/ready with credit flow control,
// collects the fixed-latency results in a FIFO and counts the job to completion.
module cell_stream_sequencer #(
   parameter int unsigned CELL_W  = 72,
   parameter int unsigned PIX_W   = 8,
   parameter int unsigned OPC_W   = 4,
   parameter int unsigned LATENCY = 4,
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned CNT_W   = 20
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [CNT_W-1:0]  pixel_total,
   input  logic [OPC_W-1:0]  opcode_in,
   input  logic [PIX_W-1:0]  user_in,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CELL_W-1:0] in_cellA,
   input  logic [CELL_W-1:0] in_cellB,
   output logic [CELL_W-1:0] core_cellA,
   output logic [CELL_W-1:0] core_cellB,
   output logic [OPC_W-1:0]  core_opcode,
   output logic [PIX_W-1:0]  core_user,
   input  logic [PIX_W-1:0]  core_pixel,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PIX_W-1:0]  out_pixel,
   output logic [CNT_W-1:0]  out_index,
   output logic              busy,
   output logic              done
);

   localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned FCNT_W = $clog2(DEPTH + 1);
   localparam int unsigned SUM_W  = $clog2(DEPTH + LATENCY + 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_t;

   state_t state, stateNext;

   logic [CNT_W-1:0]  totalReg;
   logic [CNT_W-1:0]  issued;
   logic [CNT_W-1:0]  popped;
   logic [LATENCY-1:0] validPipe;
   logic [PIX_W-1:0]  fifoMem [DEPTH];
   logic [PTR_W-1:0]  wrPtr;
   logic [PTR_W-1:0]  rdPtr;
   logic [FCNT_W-1:0] fifoCnt;
   logic [SUM_W-1:0]  inflight;
   logic              creditOk;
   logic              startGo;
   logic              accept;
   logic              push;
   logic              pop;

   function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      inflight = '0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
         inflight = inflight + SUM_W'(validPipe[i]);
      end
   end

   // Every issued cell owns a FIFO slot until popped, so the FIFO cannot overflow.
   assign creditOk  = (SUM_W'(fifoCnt) + inflight) < SUM_W'(DEPTH);
   assign in_ready  = (state == RUN) && (issued < totalReg) && creditOk;
   assign accept    = in_valid && in_ready;
   assign push      = validPipe[LATENCY-1];
   assign out_valid = (fifoCnt != '0);
   assign pop       = out_valid && out_ready;
   assign out_pixel = fifoMem[rdPtr];
   assign out_index = popped;
   assign startGo   = (state == IDLE) && start;
   assign busy      = (state == RUN) || (state == DRAIN);
   assign done      = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   always_comb begin
      stateNext = state;
      unique case (state)
         IDLE: begin
            if (start) begin
               stateNext = (pixel_total == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (issued == totalReg) begin
               stateNext = DRAIN;
            end
         end
         DRAIN: begin
            if (popped == totalReg) begin
               stateNext = DONE;
            end
         end
         DONE: begin
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         totalReg    <= '0;
         core_opcode <= '0;
         core_user   <= '0;
         issued      <= '0;
         popped      <= '0;
      end else begin
         if (startGo) begin
            totalReg    <= pixel_total;
            core_opcode <= opcode_in;
            core_user   <= user_in;
            issued      <= '0;
            popped      <= '0;
         end else begin
            if (accept) begin
               issued <= issued + 1'b1;
            end
            if (pop) begin
               popped <= popped + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         core_cellA <= '0;
         core_cellB <= '0;
         validPipe  <= '0;
      end else begin
         if (accept) begin
            core_cellA <= in_cellA;
            core_cellB <= in_cellB;
         end
         validPipe[0] <= accept;
         for (int unsigned i = 1; i < LATENCY; i++) begin
            validPipe[i] <= validPipe[i-1];
         end
      end
   end

   // The pipe tail marks the edge at which core_pixel belongs to an issued cell.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr   <= '0;
         rdPtr   <= '0;
         fifoCnt <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            fifoMem[i] <= '0;
         end
      end else begin
         if (push) begin
            fifoMem[wrPtr] <= core_pixel;
            wrPtr          <= ptrInc(wrPtr);
         end
         if (pop) begin
            rdPtr <= ptrInc(rdPtr);
         end
         unique case ({push, pop})
            2'b10:   fifoCnt <= fifoCnt + 1'b1;
            2'b01:   fifoCnt <= fifoCnt - 1'b1;
            default: fifoCnt <= fifoCnt;
         endcase
      end
   end

endmodule

// File: tb/tb_cell_stream_sequencer.sv
// Scoreboard bench for cell_stream_sequencer: random cell traffic, a stand-in core with fixed
// latency, and a credit/ordering reference computed from job-level counts.
module tb_cell_stream_sequencer;

   localparam int CELL_W  = 72;
   localparam int PIX_W   = 8;
   localparam int OPC_W   = 4;
   localparam int LATENCY = 4;
   localparam int DEPTH   = 8;
   localparam int CNT_W   = 20;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic [CNT_W-1:0]  pixel_total;
   logic [OPC_W-1:0]  opcode_in;
   logic [PIX_W-1:0]  user_in;
   logic              in_valid;
   logic              in_ready;
   logic [CELL_W-1:0] in_cellA;
   logic [CELL_W-1:0] in_cellB;
   logic [CELL_W-1:0] core_cellA;
   logic [CELL_W-1:0] core_cellB;
   logic [OPC_W-1:0]  core_opcode;
   logic [PIX_W-1:0]  core_user;
   logic [PIX_W-1:0]  core_pixel;
   logic              out_valid;
   logic              out_ready;
   logic [PIX_W-1:0]  out_pixel;
   logic [CNT_W-1:0]  out_index;
   logic              busy;
   logic              done;

   cell_stream_sequencer #(
      .CELL_W (CELL_W),
      .PIX_W  (PIX_W),
      .OPC_W  (OPC_W),
      .LATENCY(LATENCY),
      .DEPTH  (DEPTH),
      .CNT_W  (CNT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .pixel_total(pixel_total),
      .opcode_in  (opcode_in),
      .user_in    (user_in),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_cellA   (in_cellA),
      .in_cellB   (in_cellB),
      .core_cellA (core_cellA),
      .core_cellB (core_cellB),
      .core_opcode(core_opcode),
      .core_user  (core_user),
      .core_pixel (core_pixel),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_pixel  (out_pixel),
      .out_index  (out_index),
      .busy       (busy),
      .done       (done)
   );

   typedef struct {
      logic [PIX_W-1:0] pix;
      int               idx;
   } exp_t;

   exp_t sb[$];

   int nChecks = 0;
   int nFails  = 0;
   int cyc     = 0;
   int inMode  = 0;   // 0: in_valid held 1, 1: random
   int outMode = 0;   // 0: ready 1, 1: ready 0, 2: random, 3: toggle
   int issuedB = 0;
   int poppedB = 0;
   int totalB  = 0;
   int doneCnt = 0;
   int doneBase = 0;
   int firstAcc = -1;
   int firstOut = -1;
   logic jobActive = 1'b0;
   logic [OPC_W-1:0] jobOp = '0;
   logic [PIX_W-1:0] jobUser = '0;

   function automatic logic [PIX_W-1:0] corefn(input logic [CELL_W-1:0] a, input logic [CELL_W-1:0] b,
                                                input logic [OPC_W-1:0] op, input logic [PIX_W-1:0] u);
      logic [PIX_W-1:0] r;
      r = (a[7:0] ^ b[15:8]) + a[71:64] + {op, op};
      return r ^ u;
   endfunction

   function automatic logic [CELL_W-1:0] rand72();
      logic [95:0] t;
      t = {$urandom(), $urandom(), $urandom()};
      return t[CELL_W-1:0];
   endfunction

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Stand-in CellProcessor: result present LATENCY edges after its inputs change.
   logic [PIX_W-1:0] coreStage [LATENCY-1];
   always @(posedge clk) begin
      coreStage[0] <= corefn(core_cellA, core_cellB, core_opcode, core_user);
      for (int i = 1; i < LATENCY - 1; i++) coreStage[i] <= coreStage[i-1];
   end
   assign core_pixel = coreStage[LATENCY-2];

   // Input driver: credit rule expressed as outstanding = issued - popped.
   initial begin
      in_valid = 1'b0;
      in_cellA = '0;
      in_cellB = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            in_valid = 1'b0;
         end else begin
            in_valid = (inMode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            in_cellA = rand72();
            in_cellB = rand72();
            #1;
            check("in_ready", in_ready,
                  jobActive && (issuedB < totalB) && ((issuedB - poppedB) < DEPTH));
            if (in_valid && in_ready) begin
               sb.push_back('{corefn(in_cellA, in_cellB, jobOp, jobUser), issuedB});
               if (firstAcc < 0) firstAcc = cyc;
               issuedB++;
            end
         end
      end
   end

   // Output monitor.
   initial begin
      exp_t e;
      out_ready = 1'b0;
      forever begin
         @(negedge clk);
         case (outMode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = ~out_ready;
         endcase
         #2;
         if (rst_n) begin
            if (out_valid && firstOut < 0) firstOut = cyc;
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  check("unexpected_out", 1, 0);
               end else begin
                  e = sb.pop_front();
                  check("out_pixel", out_pixel, e.pix);
                  check("out_index", out_index, e.idx);
               end
               poppedB++;
            end
            if (done) doneCnt++;
         end
      end
   end

   task automatic start_job(input int total, input logic [OPC_W-1:0] op, input logic [PIX_W-1:0] u);
      @(negedge clk);
      start       = 1'b1;
      pixel_total = CNT_W'(total);
      opcode_in   = op;
      user_in     = u;
      jobOp       = op;
      jobUser     = u;
      totalB      = total;
      issuedB     = 0;
      poppedB     = 0;
      firstAcc    = -1;
      firstOut    = -1;
      doneBase    = doneCnt;
      @(negedge clk);
      start       = 1'b0;
      pixel_total = CNT_W'($urandom);
      opcode_in   = OPC_W'($urandom);
      user_in     = PIX_W'($urandom);
      jobActive   = 1'b1;
   endtask

   task automatic wait_done(input int maxc);
      int n;
      n = 0;
      while (doneCnt == doneBase && n < maxc) begin
         @(negedge clk);
         n++;
      end
      check("done_seen", doneCnt != doneBase, 1);
      repeat (4) @(negedge clk);
      check("done_pulses", doneCnt - doneBase, 1);
      check("sb_empty", sb.size(), 0);
      check("popped_total", poppedB, totalB);
      check("busy_after", busy, 0);
      jobActive = 1'b0;
   endtask

   initial begin
      int n;
      rst_n       = 1'b0;
      start       = 1'b0;
      pixel_total = '0;
      opcode_in   = '0;
      user_in     = '0;
      repeat (3) @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_out_index", out_index, 0);
      check("rst_out_pixel", out_pixel, 0);
      check("rst_core_cellA", core_cellA, 0);
      check("rst_core_opcode", core_opcode, 0);
      #3 rst_n = 1'b1;

      // Full-rate streaming.
      inMode = 0; outMode = 0;
      start_job(16, 4'h3, 8'hA5);
      wait_done(200);
      check("first_latency", firstOut - firstAcc, LATENCY + 1);
      check("core_opcode_held", core_opcode, 4'h3);
      check("core_user_held", core_user, 8'hA5);

      // Backpressure: credits run out at DEPTH.
      inMode = 0; outMode = 1;
      start_job(20, 4'h7, 8'h1C);
      repeat (30) @(negedge clk);
      #1;
      check("bp_accepts", issuedB, DEPTH);
      check("bp_in_ready", in_ready, 0);
      outMode = 0;
      wait_done(300);

      // Zero-length job.
      start_job(0, 4'h1, 8'h02);
      #1;
      check("zero_done", done, 1);
      check("zero_busy", busy, 0);
      @(negedge clk);
      #1;
      check("zero_done_drop", done, 0);
      wait_done(20);

      // Near-full FIFO with toggling out_ready.
      inMode = 0; outMode = 1;
      start_job(40, 4'hC, 8'h77);
      repeat (20) @(negedge clk);
      outMode = 3;
      wait_done(400);

      // Random traffic both sides.
      inMode = 1; outMode = 2;
      start_job(25, 4'h5, 8'h3E);
      wait_done(500);

      // start while busy must be ignored.
      inMode = 1; outMode = 2;
      start_job(30, 4'h9, 8'h5A);
      repeat (10) @(negedge clk);
      check("busy_mid", busy, 1);
      start       = 1'b1;
      pixel_total = CNT_W'(5);
      opcode_in   = 4'h2;
      user_in     = 8'h11;
      @(negedge clk);
      start = 1'b0;
      wait_done(600);
      check("ign_opcode", core_opcode, 4'h9);
      check("ign_user", core_user, 8'h5A);

      // Mid-job reset after 5 accepts.
      inMode = 0; outMode = 1;
      start_job(12, 4'h4, 8'h99);
      n = 0;
      while (issuedB < 5 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("mid_reached5", issuedB >= 5, 1);
      #3 rst_n = 1'b0;
      #1;
      check("mid_out_valid", out_valid, 0);
      check("mid_in_ready", in_ready, 0);
      check("mid_busy", busy, 0);
      check("mid_done", done, 0);
      sb.delete();
      issuedB   = 0;
      poppedB   = 0;
      totalB    = 0;
      jobActive = 1'b0;
      repeat (2) @(negedge clk);
      #3 rst_n = 1'b1;
      outMode = 0;
      start_job(10, 4'hE, 8'h42);
      wait_done(200);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1, "watchdog");
   end

endmodule
